// File: rtl/note_sequencer.sv
// Buffers {note, duration} song entries and plays them out one unit every UNIT_CYCLES clocks.
// Build option: define NOTE_SEQ_HOLD_LAST_EN to keep the last note on underrun instead of resting.
module note_sequencer #(
    parameter int unsigned UNIT_CYCLES = 750000,
    parameter int unsigned DEPTH       = 16,
    parameter logic [7:0]  REST_NOTE   = 8'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic [7:0]  cur_note,
    output logic [31:0] cur_time,
    output logic        playing,
    output logic        underrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(UNIT_CYCLES);
    localparam logic [TW-1:0] TICK_LAST  = TW'(UNIT_CYCLES - 1);
    localparam logic [TW-1:0] TICK_ONE   = TW'(1);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t        state;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic [TW-1:0] tick;
    logic [7:0]    dur_left;
    logic [15:0]   head;
    logic          push;
    logic          pop;
    logic          boundary;
    logic          fifo_empty;

    assign head = mem[rd_ptr];

    // Handshake: an entry transfers on any edge where in_valid and in_ready are both high.
    // A stop in PLAY suppresses that cycle's boundary, so no pop can coincide with it.
    always_comb begin
        fifo_empty = (count == '0);
        push       = in_valid && in_ready;
        boundary   = (state == PLAY) && !stop && (tick == TICK_LAST);
        pop        = boundary && (dur_left <= 8'd1) && !fifo_empty;
        count_next = count;
        if (push && !pop) begin
            count_next = count + COUNT_ONE;
        end else if (pop && !push) begin
            count_next = count - COUNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b1;
            tick     <= '0;
            dur_left <= 8'd0;
            cur_note <= REST_NOTE;
            cur_time <= 32'd0;
            playing  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            count    <= count_next;
            in_ready <= (count_next != FULL_COUNT);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            case (state)
                IDLE: begin
                    tick <= '0;
                    if (start && !stop) begin
                        // Preload so the very first PLAY cycle is a unit boundary.
                        state    <= PLAY;
                        playing  <= 1'b1;
                        underrun <= 1'b0;
                        tick     <= TICK_LAST;
                    end
                end
                PLAY: begin
                    if (stop) begin
                        state    <= IDLE;
                        playing  <= 1'b0;
                        tick     <= '0;
                        cur_note <= REST_NOTE;
                        dur_left <= 8'd0;
                    end else begin
                        tick <= boundary ? '0 : tick + TICK_ONE;
                        if (boundary) begin
                            cur_time <= cur_time + 32'd1;
                            if (dur_left > 8'd1) begin
                                dur_left <= dur_left - 8'd1;
                            end else if (!fifo_empty) begin
                                cur_note <= head[15:8];
                                dur_left <= (head[7:0] == 8'd0) ? 8'd1 : head[7:0];
                            end else begin
                                underrun <= 1'b1;
                                dur_left <= 8'd0;
`ifdef NOTE_SEQ_HOLD_LAST_EN
                                cur_note <= cur_note;
`else
                                cur_note <= REST_NOTE;
`endif
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: vector table for FIFO fill / idle behaviour, scoreboard of expected notes per unit.
module tb_note_sequencer;

    localparam int UNIT = 4;
    localparam int DEP  = 4;
`ifdef NOTE_SEQ_HOLD_LAST_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0000;
    logic [7:0]  cur_note;
    logic [31:0] cur_time;
    logic        playing;
    logic        underrun;

    int errors = 0;
    int checks = 0;

    // Each element is one expected unit: bit 8 marks the first unit of an entry, [7:0] is the note.
    logic [8:0] exp_q[$];

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        s;
        logic        p;
        logic        exp_ready;
        logic        exp_playing;
        logic [7:0]  exp_note;
    } vec_t;

    vec_t vecs[7];

    note_sequencer #(.UNIT_CYCLES(UNIT), .DEPTH(DEP), .REST_NOTE(8'd0)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .stop(stop),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .cur_note(cur_note),
        .cur_time(cur_time),
        .playing(playing),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input logic [7:0] n, input logic [7:0] d);
        int eff;
        eff = (d == 8'd0) ? 1 : int'(d);
        for (int k = 0; k < eff; k++) begin
            exp_q.push_back({(k == 0), n});
        end
    endtask

    // A stop discards whatever is left of the note in progress.
    task automatic drop_current();
        while (exp_q.size() > 0 && exp_q[0][8] == 1'b0) begin
            void'(exp_q.pop_front());
        end
    endtask

    task automatic push_entry(input logic [7:0] n, input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = {n, d};
        for (int c = 0; c < 20 && !ok; c++) begin
            if (in_ready) begin
                ok = 1'b1;
                sb_push(n, d);
            end
            step();
        end
        in_valid = 1'b0;
        check("push_accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_time(input logic [31:0] t, input int budget);
        int c;
        c = 0;
        while (cur_time != t && c < budget) begin
            step();
            c++;
        end
        check("wait_time", cur_time, t);
    endtask

    // Monitor: every cur_time change consumes one expected unit from the scoreboard.
    logic [31:0] prev_time = 32'd0;
    logic [7:0]  last_note = 8'd0;
    int          gap = 0;
    bit          gap_valid = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_time = 32'd0;
            gap = 0;
            gap_valid = 1'b0;
        end else begin
            gap++;
            if (cur_time != prev_time) begin
                logic [8:0] e;
                check("time_step", cur_time, prev_time + 32'd1);
                if (gap_valid) check("unit_gap", gap, UNIT);
                if (exp_q.size() == 0) begin
                    check("underrun_flag", {31'd0, underrun}, 32'd1);
                    check("underrun_note", {24'd0, cur_note}, {24'd0, (HOLD ? last_note : 8'd0)});
                end else begin
                    e = exp_q.pop_front();
                    check("unit_note", {24'd0, cur_note}, {24'd0, e[7:0]});
                    last_note = e[7:0];
                end
                prev_time = cur_time;
                gap = 0;
                gap_valid = playing;
            end
            if (!playing) gap_valid = 1'b0;
        end
    end

    initial begin
        // Reset with an entry offered: nothing may be captured.
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_data = 16'h0A01;
        repeat (3) step();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_cur_note", {24'd0, cur_note}, 32'd0);
        check("rst_cur_time", cur_time, 32'd0);
        check("rst_playing", {31'd0, playing}, 32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Fill the FIFO; 5th offer refused; start with stop stays idle.
        vecs[0] = '{1'b1, 16'h3C02, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[1] = '{1'b1, 16'h3E01, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[2] = '{1'b1, 16'h4000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[3] = '{1'b1, 16'h4201, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[4] = '{1'b1, 16'h4401, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[6] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        for (int i = 0; i < 7; i++) begin
            in_valid = vecs[i].v;
            in_data  = vecs[i].d;
            start    = vecs[i].s;
            stop     = vecs[i].p;
            if (vecs[i].v && in_ready) sb_push(vecs[i].d[15:8], vecs[i].d[7:0]);
            step();
            check($sformatf("vec%0d_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].exp_ready});
            check($sformatf("vec%0d_playing", i), {31'd0, playing}, {31'd0, vecs[i].exp_playing});
            check($sformatf("vec%0d_note", i), {24'd0, cur_note}, {24'd0, vecs[i].exp_note});
        end
        in_valid = 1'b0;
        start = 1'b0;
        stop = 1'b0;

        // Start: playing after edge N, first unit after edge N+1, space frees after the first pop.
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_playing", {31'd0, playing}, 32'd1);
        check("start_full", {31'd0, in_ready}, 32'd0);
        check("start_time_held", cur_time, 32'd0);
        step();
        check("first_note", {24'd0, cur_note}, 32'd60);
        check("first_time", cur_time, 32'd1);
        check("ready_after_pop", {31'd0, in_ready}, 32'd1);
        push_entry(8'd68, 8'd1);
        wait_time(32'd7, 80);
        check("underrun_set", {31'd0, underrun}, 32'd1);
        check("underrun_note_a", {24'd0, cur_note}, {24'd0, (HOLD ? 8'd68 : 8'd0)});
        stop = 1'b1;
        step();
        stop = 1'b0;
        drop_current();
        check("stop_playing", {31'd0, playing}, 32'd0);
        check("stop_note", {24'd0, cur_note}, 32'd0);
        check("underrun_sticky", {31'd0, underrun}, 32'd1);

        // Stop mid-note and resume: remainder dropped, order kept, cur_time held.
        push_entry(8'd72, 8'd3);
        push_entry(8'd74, 8'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_playing", {31'd0, playing}, 32'd1);
        check("underrun_cleared", {31'd0, underrun}, 32'd0);
        wait_time(32'd9, 40);
        check("mid_note", {24'd0, cur_note}, 32'd72);
        stop = 1'b1;
        step();
        stop = 1'b0;
        drop_current();
        check("mid_stop_note", {24'd0, cur_note}, 32'd0);
        repeat (5) step();
        check("idle_time_held", cur_time, 32'd9);
        check("idle_playing", {31'd0, playing}, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_time(32'd10, 40);
        check("resume_note", {24'd0, cur_note}, 32'd74);
        wait_time(32'd11, 40);
        check("underrun_b", {31'd0, underrun}, 32'd1);
        check("underrun_note_b", {24'd0, cur_note}, {24'd0, (HOLD ? 8'd74 : 8'd0)});
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        check("sb_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
